// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder and subtractor).
package bit_serial_pkg;

    // Default operand width shared by the serial adder and subtractor.
    localparam int DEFAULT_WIDTH = 8;

    // Sequencer states; the unused code 2'd3 recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bit_serial_subtractor_if.sv
// Handshake and data bundle between a requester and the bit-serial subtractor.
interface bit_serial_subtractor_if
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             serial_out;

    // Requester side: issues start with operands, observes status and result.
    modport master (
        output start, a, b,
        input  busy, done, diff, bout, ovf, serial_out
    );

    // Subtractor side.
    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, ovf, serial_out
    );

endinterface

// File: rtl/bit_serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when y exceeds x, or when they are equal and a borrow comes in.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// LSB-first bit-serial subtractor: one full-subtractor cell plus a borrow flop,
// one bit per clock, with start/busy/done handshake and registered result.
module bit_serial_subtractor
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    bit_serial_subtractor_if.slave bus
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   ra;
    logic [WIDTH-1:0]   rb;
    logic [WIDTH-1:0]   rd;
    logic               br;
    logic [CNT_W-1:0]   cnt;
    logic               sa;
    logic               sb;

    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;
    logic               ovf_q;

    logic               d;
    logic               br_next;

    // Signed overflow of a - b: operand signs differ and the result sign
    // disagrees with the minuend.
    function automatic logic sub_ovf(input logic s_a, input logic s_b, input logic s_r);
        return (s_a ^ s_b) & (s_a ^ s_r);
    endfunction

    full_subtractor u_cell (
        .x    (ra[0]),
        .y    (rb[0]),
        .bin  (br),
        .d    (d),
        .bout (br_next)
    );

    // Sequencer, operand/result shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            ra     <= '0;
            rb     <= '0;
            rd     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        ra     <= bus.a;
                        rb     <= bus.b;
                        rd     <= '0;
                        br     <= 1'b0;
                        cnt    <= '0;
                        sa     <= bus.a[WIDTH-1];
                        sb     <= bus.b[WIDTH-1];
                        busy_q <= 1'b1;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    rd  <= {d, rd[WIDTH-1:1]};
                    br  <= br_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        // Last bit: publish the complete result so it is
                        // visible during the done cycle.
                        diff_q <= {d, rd[WIDTH-1:1]};
                        bout_q <= br_next;
                        ovf_q  <= sub_ovf(sa, sb, d);
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.bout       = bout_q;
    assign bus.ovf        = ovf_q;
    // Live difference bit, forced low outside the shifting window.
    assign bus.serial_out = busy_q & d;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed bench for bit_serial_subtractor (WIDTH=8).
module tb_bit_serial_subtractor;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    bit_serial_subtractor_if #(.WIDTH(8)) bus ();

    bit_serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launches one operation and observes 12 cycles after the accepting edge.
    // Cycle k=1 is the first cycle after the accepting edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] ser, output int busy_cycles,
                          output int first_busy, output int done_cycle,
                          output int done_len, output logic [7:0] diff,
                          output logic bout, output logic ovf);
        ser = '0; busy_cycles = 0; first_busy = 0; done_cycle = 0; done_len = 0;
        diff = '0; bout = 1'b0; ovf = 1'b0;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        step();
        bus.start = 1'b0;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        for (int k = 1; k <= 12; k++) begin
            if (bus.busy) begin
                if (first_busy == 0) first_busy = k;
                if (busy_cycles < 8) ser[busy_cycles[2:0]] = bus.serial_out;
                busy_cycles++;
            end
            if (bus.done) begin
                if (done_cycle == 0) begin
                    done_cycle = k;
                    diff = bus.diff;
                    bout = bus.bout;
                    ovf  = bus.ovf;
                end
                done_len++;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        step();
        step();
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++;
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        vectors++;
        if (bus.diff !== 8'h00) begin miscompares++; $display("FAIL reset_diff: got %h expected 00", bus.diff); end
        vectors++;
        if ({bus.bout, bus.ovf, bus.serial_out} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags: got %b expected 000", {bus.bout, bus.ovf, bus.serial_out});
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] ser, diff; logic bout, ovf; int bc, fb, dc, dl;
        run_op(8'h3C, 8'h15, ser, bc, fb, dc, dl, diff, bout, ovf);
        vectors++;
        if (bc !== 8 || fb !== 1) begin miscompares++; $display("FAIL basic_busy: got count %0d first %0d expected 8/1", bc, fb); end
        vectors++;
        if (dc !== 9 || dl !== 1) begin miscompares++; $display("FAIL basic_done: got cycle %0d len %0d expected 9/1", dc, dl); end
        vectors++;
        if (ser !== 8'h27) begin miscompares++; $display("FAIL basic_serial: got %b expected 00100111", ser); end
        vectors++;
        if ({diff, bout, ovf} !== {8'h27, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL basic_result: got %h/%b/%b expected 27/0/0", diff, bout, ovf);
        end
    endtask

    task automatic test_borrow();
        logic [7:0] ser, diff; logic bout, ovf; int bc, fb, dc, dl;
        run_op(8'h05, 8'h0A, ser, bc, fb, dc, dl, diff, bout, ovf);
        vectors++;
        if ({diff, bout, ovf} !== {8'hFB, 1'b1, 1'b0} || ser !== 8'hFB) begin
            miscompares++; $display("FAIL borrow: got %h/%b/%b ser %h expected FB/1/0 ser FB", diff, bout, ovf, ser);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] ser, diff; logic bout, ovf; int bc, fb, dc, dl;
        run_op(8'h80, 8'h01, ser, bc, fb, dc, dl, diff, bout, ovf);
        vectors++;
        if ({diff, bout, ovf} !== {8'h7F, 1'b0, 1'b1}) begin
            miscompares++; $display("FAIL ovf_80_01: got %h/%b/%b expected 7F/0/1", diff, bout, ovf);
        end
        run_op(8'h7F, 8'hFF, ser, bc, fb, dc, dl, diff, bout, ovf);
        vectors++;
        if ({diff, bout, ovf} !== {8'h80, 1'b1, 1'b1}) begin
            miscompares++; $display("FAIL ovf_7F_FF: got %h/%b/%b expected 80/1/1", diff, bout, ovf);
        end
    endtask

    task automatic test_equal();
        logic [7:0] ser, diff; logic bout, ovf; int bc, fb, dc, dl;
        run_op(8'h00, 8'h00, ser, bc, fb, dc, dl, diff, bout, ovf);
        vectors++;
        if ({diff, bout, ovf} !== 10'b0 || dl !== 1) begin
            miscompares++; $display("FAIL equal_00: got %h/%b/%b len %0d expected 00/0/0 len 1", diff, bout, ovf, dl);
        end
        run_op(8'hFF, 8'hFF, ser, bc, fb, dc, dl, diff, bout, ovf);
        vectors++;
        if ({diff, bout, ovf} !== 10'b0 || dl !== 1 || dc !== 9) begin
            miscompares++; $display("FAIL equal_FF: got %h/%b/%b len %0d cyc %0d expected 00/0/0 len 1 cyc 9", diff, bout, ovf, dl, dc);
        end
    endtask

    task automatic test_hold_start();
        int first_done, second_busy, second_done;
        logic [7:0] d1, d2;
        first_done = 0; second_busy = 0; second_done = 0; d1 = '0; d2 = '0;
        bus.start = 1'b1;
        bus.a = 8'h3C;
        bus.b = 8'h15;
        step();
        bus.a = 8'h05;
        bus.b = 8'h0A;
        for (int k = 1; k <= 22; k++) begin
            if (bus.done && first_done == 0) begin first_done = k; d1 = bus.diff; end
            else if (bus.done && second_done == 0) begin second_done = k; d2 = bus.diff; end
            if (bus.busy && first_done != 0 && second_busy == 0) begin
                second_busy = k;
                bus.start = 1'b0;
            end
            step();
        end
        bus.start = 1'b0;
        vectors++;
        if (first_done !== 9 || d1 !== 8'h27) begin
            miscompares++; $display("FAIL hold_first: got cycle %0d diff %h expected 9/27", first_done, d1);
        end
        vectors++;
        if (second_busy !== 11) begin miscompares++; $display("FAIL hold_reaccept: got busy at %0d expected 11", second_busy); end
        vectors++;
        if (second_done !== 19 || d2 !== 8'hFB) begin
            miscompares++; $display("FAIL hold_second: got cycle %0d diff %h expected 19/FB", second_done, d2);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] ser, diff; logic bout, ovf; int bc, fb, dc, dl;
        bus.start = 1'b1;
        bus.a = 8'h3C;
        bus.b = 8'h15;
        step();
        bus.start = 1'b0;
        for (int k = 1; k < 4; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if ({bus.busy, bus.done, bus.serial_out} !== 3'b000) begin
            miscompares++; $display("FAIL midreset_ctrl: got busy/done/ser %b expected 000", {bus.busy, bus.done, bus.serial_out});
        end
        vectors++;
        if ({bus.diff, bus.bout, bus.ovf} !== 10'b0) begin
            miscompares++; $display("FAIL midreset_result: got %h/%b/%b expected 00/0/0", bus.diff, bus.bout, bus.ovf);
        end
        run_op(8'h10, 8'h01, ser, bc, fb, dc, dl, diff, bout, ovf);
        vectors++;
        if ({diff, bout, ovf} !== {8'h0F, 1'b0, 1'b0} || dc !== 9 || bc !== 8) begin
            miscompares++; $display("FAIL midreset_after: got %h/%b/%b cyc %0d busy %0d expected 0F/0/0 cyc 9 busy 8", diff, bout, ovf, dc, bc);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_equal();
        test_hold_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bit_serial_subtractor.md
# bit_serial_subtractor

Sequential LSB-first bit-serial subtractor computing a − b for two WIDTH-bit operands. It uses one full-subtractor cell and a borrow flip-flop, consuming one bit per clock. It is the inverse-operation companion to the bit-serial binary adder in the arithmetic lab set. It exposes a start/busy/done handshake, a registered parallel result with borrow-out and signed-overflow flags, and a live serial difference stream.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 2–32.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
- start  input  1  request to begin; accepted only in IDLE.
- a  input  WIDTH  minuend, sampled on the accepting edge only.
- b  input  WIDTH  subtrahend, sampled on the accepting edge only.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse when the result is valid.
- diff  output  WIDTH  registered difference (a − b) mod 2^WIDTH.
- bout  output  1  final borrow: 1 when a < b unsigned.
- ovf  output  1  two's-complement signed overflow of a − b.
- serial_out  output  1  difference bit produced this cycle; 0 when busy is low.

## Operation
- Internal state: shift registers ra and rb (WIDTH bits each), result shift register rd (WIDTH bits), borrow flop br, bit counter cnt of width $clog2(WIDTH+1), and sign bits sa and sb captured at load.
- Per-bit cell, with x = ra[0], y = rb[0]:
  - d = x ^ y ^ br
  - br_next = (~x & y) | (~(x ^ y) & br)
- FSM states and transitions:
  - IDLE: start=1 → load ra=a, rb=b, br=0, cnt=0, capture sa=a[WIDTH-1] and sb=b[WIDTH-1], clear rd; go to SHIFT.
  - SHIFT: each cycle shift ra and rb right by one, shift d into rd at the MSB (rd = {d, rd[WIDTH-1:1]}), set br=br_next, increment cnt. When cnt reaches WIDTH-1 on this edge, go to DONE.
  - DONE: on this edge, set diff=rd, bout=br, ovf=(sa ^ sb) & (sa ^ rd[WIDTH-1]); go to IDLE.
- done is high exactly during the single cycle the FSM is in DONE (the first cycle the new result is visible).
- diff, bout and ovf hold their values until the next DONE cycle or a reset.
- start is ignored in SHIFT and DONE; there is no queuing. a and b may change freely after the accepting edge.
- reset overrides everything, including mid-operation:
  - state goes to IDLE;
  - ra, rb, rd, br, cnt, sa and sb clear to 0;
  - all outputs clear to 0.
- Reset values of all outputs: busy 0, done 0, diff 0, bout 0, ovf 0, serial_out 0.

## Timing
- Start accepted at edge T.
- busy is high during cycles T+1 through T+WIDTH, exactly WIDTH cycles.
- serial_out = d combinationally during the busy cycles, LSB first: bit i appears in cycle T+1+i.
- done, diff, bout and ovf become valid in cycle T+WIDTH+1.
- The FSM returns to IDLE at T+WIDTH+2. The earliest next accepted start is on edge T+WIDTH+2.
- Total latency from start to done is WIDTH+1 cycles. Throughput is one operation per WIDTH+2 cycles.
- A start asserted during the done cycle is not accepted.
- A reset asserted at any edge takes effect on that edge; busy and done are low in the following cycle.

## Structure
- Shared package/header bit_serial_pkg holds:
  - state encodings S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2 (2'd3 is illegal and recovers to S_IDLE);
  - the default WIDTH constant, shared with the serial adder.
- One combinational sub-module, full_subtractor: ports x, y, bin, d, bout. It implements the per-bit cell above.
- Everything else (FSM, shift registers, counter, flag logic) lives in bit_serial_subtractor.

## Test plan
All scenarios use WIDTH=8.
- a=0x3C, b=0x15, start at T → busy high for 8 cycles; done at T+9 with diff=0x27, bout=0, ovf=0; serial_out sequence 1,1,1,0,0,1,0,0.
- a=0x05, b=0x0A → diff=0xFB, bout=1, ovf=0.
- a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
- a=0x00, b=0x00 and a=0xFF, b=0xFF → diff=0x00, bout=0, ovf=0. done pulse is exactly one cycle.
- Hold start high continuously from T, with the operands changed at T+1 → only the T operands are processed. The next acceptance is at T+10, and the result at T+9 reflects the first operands.
- reset asserted at T+4 mid-SHIFT → next cycle busy=0, done=0, diff=0, serial_out=0, state IDLE. A following start with a=0x10, b=0x01 gives diff=0x0F, bout=0, ovf=0 at the correct latency.
